curve_contrast_lut_stream: RTL and testbench
============================================

Name: curve_contrast_lut_stream

Overview:
- Runtime-loadable, multi-channel contrast-curve lookup for the video pipeline (vip). Generalises the fixed S-curve tables to any DATA_W and CH_NUM.
- Holds a double-banked curve table: software writes the shadow bank, and the banks swap only at a frame boundary.
- Pixels pass identity-mapped until the first curve is committed.
- Sits between colour-space/grey conversion and the downstream filters; uses the per_frame_*/post_frame_* sync convention.

Parameters:
- DATA_W, 8, pixel component width; table depth is 2**DATA_W.
- CH_NUM, 3, number of parallel channels; all channels share one curve, with one replicated read port per channel.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  async active-low reset.
- per_frame_vsync  in  1  input vsync, active high.
- per_frame_href  in  1  input line valid.
- per_frame_clken  in  1  input pixel valid.
- per_img_data  in  CH_NUM*DATA_W  input pixels; channel 0 in the LSBs.
- post_frame_vsync  out  1  vsync delayed 2 cycles.
- post_frame_href  out  1  href delayed 2 cycles.
- post_frame_clken  out  1  clken delayed 2 cycles.
- post_img_data  out  CH_NUM*DATA_W  mapped pixels.
- cfg_wr_en  in  1  table write strobe.
- cfg_wr_addr  in  DATA_W  table index.
- cfg_wr_data  in  DATA_W  curve value.
- cfg_commit  in  1  one-cycle request to activate the shadow bank.
- cfg_ready  out  1  high when writes and commits are accepted (= ~pending).
- curve_active  out  1  0 = identity bypass, 1 = table mapping in use.
- swap_pulse  out  1  one-cycle pulse when a bank swap occurs.

Behaviour:
- Reset (async, rst_n=0):
  - All post_* outputs, swap_pulse and curve_active are 0; cfg_ready is 1.
  - Internal: active_sel=0, pending=0, vsync_d=0.
  - Table memory is not cleared.
- Latency is exactly 2 cycles for data and all three sync signals.
  - Stage 1 registers the sync signals, the per-channel read addresses and a bank/bypass snapshot (active_sel, curve_active).
  - Stage 2 outputs the synchronous-read table value, or the stage-1 pixel if the snapshot bypass=1.
- Data is updated every cycle regardless of clken; downstream qualifies it with post_frame_clken.
- Writes: cfg_wr_en && !pending writes cfg_wr_data to [bank ~active_sel][cfg_wr_addr] in all CH_NUM replicas. Writes while pending are dropped with no error.
- Commit: cfg_commit && !pending sets pending=1 on the next edge. A commit while pending is ignored.
- Swap: when pending==1 and a vsync rising edge is detected (per_frame_vsync && !vsync_d), on that edge:
  - active_sel toggles, pending clears, curve_active sets to 1;
  - swap_pulse=1 for the following cycle.
- A commit issued in the same cycle as a vsync rise does not swap in that cycle; the swap occurs at the next vsync rise.
- After a swap, the new shadow bank holds the previous curve. Software must rewrite all 2**DATA_W entries before the next commit; partial rewrites leave stale entries by design.
- Mid-frame commit: pixels of the current frame keep the old bank (or bypass). The change applies from the next frame only, so there is no tearing.
- Pixels already in the pipeline use the bank snapshot taken at stage 1, so a swap never changes a pixel already in flight.
- Write and read of the same address in the same cycle cannot conflict: writes only target the shadow bank.
- Reset mid-frame: the pipeline flushes and the block returns to bypass; a committed curve is lost until it is recommitted.

Decomposition:
- Shared package vip_pkg: DATA_W default, CH_NUM default, and a localparam LUT_DEPTH = 2**DATA_W.
- Sub-module curve_lut_bank_ram: one 2-bank simple dual-port RAM with a synchronous read, depth 2*LUT_DEPTH and address {bank, index}. It is instantiated CH_NUM times, and its write port is broadcast to all instances.
- The top level holds the sync delay line, the pending/active_sel FSM (states BYPASS, ACTIVE, PENDING_FROM_BYPASS, PENDING_FROM_ACTIVE) and the output muxing.

Test Plan:
- Reset, then stream pixels 0x00..0xFF on all 3 channels → outputs equal inputs after 2 cycles; curve_active=0; post sync signals match inputs delayed by 2.
- Write the inverse curve (v → 0xFF-v), commit mid-frame → the rest of the frame stays identity; at the next vsync rise swap_pulse fires once; the next frame maps 0x10→0xEF, 0x80→0x7F, 0xFF→0x00 on all channels.
- Try to write 0x55 to address 0x10 and commit again while pending → cfg_ready=0, the write and commit are dropped; after the swap, 0x10 still maps to 0xEF.
- Commit asserted in the same cycle as a vsync rise → no swap on that edge; swap at the following vsync rise.
- Load the identity curve into the shadow bank with active=inverse, commit, then swap → frame N outputs the inverse curve, frame N+1 outputs identity; pixels already in flight at the swap keep the old mapping.
- Assert rst_n=0 mid-frame while the curve is active → outputs go to 0 immediately; after release, pixels pass identity with curve_active=0.

Source files
------------

// File: rtl/vip_pkg.sv
// Shared definitions for the video-pipeline contrast-curve block.
// Default geometry and the curve-bank control states.
package vip_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CH_NUM = 3;
    localparam int LUT_DEPTH  = 2 ** DEF_DATA_W;

    typedef enum logic [1:0] {
        BYPASS,
        ACTIVE,
        PENDING_FROM_BYPASS,
        PENDING_FROM_ACTIVE
    } curve_state_t;

endpackage

// File: rtl/curve_lut_bank_ram.sv
// Two-bank curve table, one per channel; address is {bank, index}.
// Simple dual-port: one write port, one synchronous read port.
module curve_lut_bank_ram
    import vip_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [DATA_W:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 * (2 ** DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Table storage is deliberately not reset; read is registered.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/curve_contrast_lut_stream.sv
// Multi-channel contrast curve with a double-banked, frame-swapped table.
// Pixels bypass until the first curve is committed; latency is 2 cycles.
module curve_contrast_lut_stream
    import vip_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH_NUM = DEF_CH_NUM
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     per_frame_vsync,
    input  logic                     per_frame_href,
    input  logic                     per_frame_clken,
    input  logic [CH_NUM*DATA_W-1:0] per_img_data,
    output logic                     post_frame_vsync,
    output logic                     post_frame_href,
    output logic                     post_frame_clken,
    output logic [CH_NUM*DATA_W-1:0] post_img_data,
    input  logic                     cfg_wr_en,
    input  logic [DATA_W-1:0]        cfg_wr_addr,
    input  logic [DATA_W-1:0]        cfg_wr_data,
    input  logic                     cfg_commit,
    output logic                     cfg_ready,
    output logic                     curve_active,
    output logic                     swap_pulse
);

    curve_state_t state;
    curve_state_t state_nx;

    logic active_sel;
    logic sel_nx;
    logic vsync_d;
    logic vsync_rise;
    logic pending;
    logic swap;

    logic wr_en;
    logic [DATA_W:0] wr_addr;

    logic vs1, hr1, ck1;
    logic vs2, hr2, ck2;
    logic sel1;
    logic byp1, byp2;
    logic [CH_NUM*DATA_W-1:0] pix1;
    logic [CH_NUM*DATA_W-1:0] pix2;
    logic [CH_NUM*DATA_W-1:0] rdata;

    assign vsync_rise = per_frame_vsync && !vsync_d;
    assign pending = (state == PENDING_FROM_BYPASS) ||
                     (state == PENDING_FROM_ACTIVE);
    assign cfg_ready = !pending;
    assign curve_active = (state == ACTIVE) ||
                          (state == PENDING_FROM_ACTIVE);

    // Software only ever writes the shadow bank, never the live one.
    assign wr_en = cfg_wr_en && !pending;
    assign wr_addr = {~active_sel, cfg_wr_addr};

    // Next-state: a commit arms the swap, a vsync rise performs it.
    always_comb begin
        state_nx = state;
        sel_nx = active_sel;
        swap = 1'b0;
        unique case (state)
            BYPASS: begin
                if (cfg_commit) state_nx = PENDING_FROM_BYPASS;
            end
            ACTIVE: begin
                if (cfg_commit) state_nx = PENDING_FROM_ACTIVE;
            end
            PENDING_FROM_BYPASS,
            PENDING_FROM_ACTIVE: begin
                if (vsync_rise) begin
                    state_nx = ACTIVE;
                    sel_nx = ~active_sel;
                    swap = 1'b1;
                end
            end
            default: state_nx = BYPASS;
        endcase
    end

    // Control state, live bank select and vsync edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BYPASS;
            active_sel <= 1'b0;
            vsync_d <= 1'b0;
            swap_pulse <= 1'b0;
        end else begin
            state <= state_nx;
            active_sel <= sel_nx;
            vsync_d <= per_frame_vsync;
            swap_pulse <= swap;
        end
    end

    // Stage 1: sync, read address and the bank/bypass snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs1 <= 1'b0;
            hr1 <= 1'b0;
            ck1 <= 1'b0;
            pix1 <= '0;
            sel1 <= 1'b0;
            byp1 <= 1'b1;
        end else begin
            vs1 <= per_frame_vsync;
            hr1 <= per_frame_href;
            ck1 <= per_frame_clken;
            pix1 <= per_img_data;
            sel1 <= active_sel;
            byp1 <= !curve_active;
        end
    end

    // Stage 2: align sync and bypass pixel with the table read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs2 <= 1'b0;
            hr2 <= 1'b0;
            ck2 <= 1'b0;
            pix2 <= '0;
            byp2 <= 1'b1;
        end else begin
            vs2 <= vs1;
            hr2 <= hr1;
            ck2 <= ck1;
            pix2 <= pix1;
            byp2 <= byp1;
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        curve_lut_bank_ram #(
            .DATA_W(DATA_W)
        ) u_ram (
            .clk    (clk),
            .wr_en  (wr_en),
            .wr_addr(wr_addr),
            .wr_data(cfg_wr_data),
            .rd_addr({sel1, pix1[c*DATA_W +: DATA_W]}),
            .rd_data(rdata[c*DATA_W +: DATA_W])
        );
    end

    // Bypass path resets to a zero pixel, so outputs read 0 in reset.
    assign post_img_data = byp2 ? pix2 : rdata;
    assign post_frame_vsync = vs2;
    assign post_frame_href = hr2;
    assign post_frame_clken = ck2;

endmodule

// File: tb/tb_curve_contrast_lut_stream.sv
// Directed bench for the banked contrast-curve stream block.
// Each scenario task drives vectors and checks hand-derived results.
module tb_curve_contrast_lut_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        per_frame_vsync = 1'b0;
    logic        per_frame_href = 1'b0;
    logic        per_frame_clken = 1'b0;
    logic [23:0] per_img_data = '0;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic [23:0] post_img_data;
    logic        cfg_wr_en = 1'b0;
    logic [7:0]  cfg_wr_addr = '0;
    logic [7:0]  cfg_wr_data = '0;
    logic        cfg_commit = 1'b0;
    logic        cfg_ready;
    logic        curve_active;
    logic        swap_pulse;

    int checks = 0;
    int failures = 0;
    int swap_cnt = 0;
    bit exp_inv = 1'b0;

    logic [7:0] cur_exp = '0;
    logic [7:0] prev_exp = '0;
    logic cur_vs = 1'b0, cur_hr = 1'b0, cur_ck = 1'b0;
    logic prev_vs = 1'b0, prev_hr = 1'b0, prev_ck = 1'b0;

    curve_contrast_lut_stream dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_href  (per_frame_href),
        .per_frame_clken (per_frame_clken),
        .per_img_data    (per_img_data),
        .post_frame_vsync(post_frame_vsync),
        .post_frame_href (post_frame_href),
        .post_frame_clken(post_frame_clken),
        .post_img_data   (post_img_data),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_wr_addr     (cfg_wr_addr),
        .cfg_wr_data     (cfg_wr_data),
        .cfg_commit      (cfg_commit),
        .cfg_ready       (cfg_ready),
        .curve_active    (curve_active),
        .swap_pulse      (swap_pulse)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus; afterwards the outputs carry the prior vector.
    task automatic drive(input logic vs, input logic hr, input logic ck,
                         input logic [7:0] p);
        prev_exp = cur_exp;
        prev_vs = cur_vs;
        prev_hr = cur_hr;
        prev_ck = cur_ck;
        per_frame_vsync = vs;
        per_frame_href = hr;
        per_frame_clken = ck;
        per_img_data = {3{p}};
        cur_exp = exp_inv ? 8'hFF - p : p;
        cur_vs = vs;
        cur_hr = hr;
        cur_ck = ck;
        @(posedge clk);
        #1;
        if (swap_pulse) swap_cnt++;
    endtask

    task automatic vsync_frame(input bit flip, input bit commit);
        cfg_commit = commit;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        cfg_commit = 1'b0;
        if (flip) exp_inv = !exp_inv;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic cfg_load(input bit inv);
        for (int a = 0; a < 256; a++) begin
            cfg_wr_en = 1'b1;
            cfg_wr_addr = 8'(a);
            cfg_wr_data = inv ? 8'(255 - a) : 8'(a);
            drive(1'b0, 1'b0, 1'b0, 8'h00);
        end
        cfg_wr_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        per_frame_vsync = 1'b1;
        per_frame_href = 1'b1;
        per_frame_clken = 1'b1;
        per_img_data = 24'hA5A5A5;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({post_frame_vsync, post_frame_href, post_frame_clken} !== 3'b000) begin
            failures++;
            $display("FAIL reset_sync got=%b want=000",
                     {post_frame_vsync, post_frame_href, post_frame_clken});
        end
        checks++;
        if (post_img_data !== 24'h0) begin
            failures++;
            $display("FAIL reset_data got=%h want=000000", post_img_data);
        end
        checks++;
        if (curve_active !== 1'b0) begin
            failures++;
            $display("FAIL reset_active got=%b want=0", curve_active);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", cfg_ready);
        end
        checks++;
        if (swap_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_swap got=%b want=0", swap_pulse);
        end
        per_frame_vsync = 1'b0;
        per_frame_href = 1'b0;
        per_frame_clken = 1'b0;
        per_img_data = '0;
        cur_exp = '0;
        cur_vs = 1'b0;
        cur_hr = 1'b0;
        cur_ck = 1'b0;
        exp_inv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_identity;
        vsync_frame(1'b0, 1'b0);
        for (int i = 0; i <= 256; i++) begin
            drive(1'b0, i < 256, i < 256, 8'(i));
            checks++;
            if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_data}
                !== {prev_vs, prev_hr, prev_ck, {3{prev_exp}}}) begin
                failures++;
                $display("FAIL identity i=%0d got=%h want=%h", i,
                         {post_frame_vsync, post_frame_href, post_frame_clken,
                          post_img_data},
                         {prev_vs, prev_hr, prev_ck, {3{prev_exp}}});
            end
        end
        checks++;
        if (curve_active !== 1'b0) begin
            failures++;
            $display("FAIL identity_active got=%b want=0", curve_active);
        end
    endtask

    task automatic test_inverse_commit;
        cfg_load(1'b1);
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_ready got=%b want=1", cfg_ready);
        end
        drive(1'b0, 1'b1, 1'b1, 8'h10);
        cfg_commit = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'h80);
        cfg_commit = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL commit_ready got=%b want=0", cfg_ready);
        end
        checks++;
        if (curve_active !== 1'b0) begin
            failures++;
            $display("FAIL commit_active got=%b want=0", curve_active);
        end
        drive(1'b0, 1'b1, 1'b1, 8'hFF);
        checks++;
        if (post_img_data !== 24'h808080) begin
            failures++;
            $display("FAIL midframe_80 got=%h want=808080", post_img_data);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (post_img_data !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL midframe_ff got=%h want=ffffff", post_img_data);
        end
    endtask

    task automatic test_pending_drop;
        int s0;
        s0 = swap_cnt;
        cfg_wr_en = 1'b1;
        cfg_wr_addr = 8'h10;
        cfg_wr_data = 8'h55;
        cfg_commit = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'h20);
        cfg_wr_en = 1'b0;
        cfg_commit = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL pend_ready got=%b want=0", cfg_ready);
        end
        vsync_frame(1'b1, 1'b0);
        checks++;
        if (swap_cnt - s0 !== 1) begin
            failures++;
            $display("FAIL swap_count got=%0d want=1", swap_cnt - s0);
        end
        checks++;
        if ({curve_active, cfg_ready} !== 2'b11) begin
            failures++;
            $display("FAIL swap_state got=%b want=11", {curve_active, cfg_ready});
        end
        drive(1'b0, 1'b1, 1'b1, 8'h10);
        drive(1'b0, 1'b1, 1'b1, 8'h80);
        checks++;
        if (post_img_data !== 24'hEFEFEF) begin
            failures++;
            $display("FAIL map_10 got=%h want=efefef", post_img_data);
        end
        drive(1'b0, 1'b1, 1'b1, 8'hFF);
        checks++;
        if (post_img_data !== 24'h7F7F7F) begin
            failures++;
            $display("FAIL map_80 got=%h want=7f7f7f", post_img_data);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (post_img_data !== 24'h000000) begin
            failures++;
            $display("FAIL map_ff got=%h want=000000", post_img_data);
        end
    endtask

    task automatic test_swap_to_identity;
        int s0;
        cfg_load(1'b0);
        cfg_commit = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        cfg_commit = 1'b0;
        s0 = swap_cnt;
        drive(1'b0, 1'b1, 1'b1, 8'h10);
        drive(1'b0, 1'b1, 1'b1, 8'h40);
        checks++;
        if (post_img_data !== 24'hEFEFEF) begin
            failures++;
            $display("FAIL frameN_10 got=%h want=efefef", post_img_data);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h50);
        exp_inv = 1'b0;
        checks++;
        if (post_img_data !== 24'hBFBFBF) begin
            failures++;
            $display("FAIL frameN_40 got=%h want=bfbfbf", post_img_data);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h60);
        checks++;
        if (post_img_data !== 24'hAFAFAF) begin
            failures++;
            $display("FAIL inflight_50 got=%h want=afafaf", post_img_data);
        end
        drive(1'b0, 1'b1, 1'b1, 8'h10);
        checks++;
        if (post_img_data !== 24'h606060) begin
            failures++;
            $display("FAIL after_swap_60 got=%h want=606060", post_img_data);
        end
        drive(1'b0, 1'b1, 1'b1, 8'h80);
        checks++;
        if (post_img_data !== 24'h101010) begin
            failures++;
            $display("FAIL frameN1_10 got=%h want=101010", post_img_data);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (post_img_data !== 24'h808080) begin
            failures++;
            $display("FAIL frameN1_80 got=%h want=808080", post_img_data);
        end
        checks++;
        if (swap_cnt - s0 !== 1) begin
            failures++;
            $display("FAIL swap2_count got=%0d want=1", swap_cnt - s0);
        end
    endtask

    task automatic test_commit_on_vsync;
        int s0;
        s0 = swap_cnt;
        vsync_frame(1'b0, 1'b1);
        checks++;
        if (swap_cnt - s0 !== 0) begin
            failures++;
            $display("FAIL same_edge_swap got=%0d want=0", swap_cnt - s0);
        end
        checks++;
        if ({cfg_ready, curve_active} !== 2'b01) begin
            failures++;
            $display("FAIL same_edge_state got=%b want=01",
                     {cfg_ready, curve_active});
        end
        drive(1'b0, 1'b1, 1'b1, 8'h10);
        drive(1'b0, 1'b1, 1'b1, 8'hFF);
        checks++;
        if (post_img_data !== 24'h101010) begin
            failures++;
            $display("FAIL same_edge_10 got=%h want=101010", post_img_data);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (post_img_data !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL same_edge_ff got=%h want=ffffff", post_img_data);
        end
        vsync_frame(1'b1, 1'b0);
        checks++;
        if (swap_cnt - s0 !== 1) begin
            failures++;
            $display("FAIL next_edge_swap got=%0d want=1", swap_cnt - s0);
        end
        drive(1'b0, 1'b1, 1'b1, 8'h80);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (post_img_data !== 24'h7F7F7F) begin
            failures++;
            $display("FAIL next_edge_80 got=%h want=7f7f7f", post_img_data);
        end
    endtask

    task automatic test_reset_mid_frame;
        drive(1'b0, 1'b1, 1'b1, 8'h10);
        drive(1'b0, 1'b1, 1'b1, 8'h20);
        checks++;
        if (post_img_data !== 24'hEFEFEF) begin
            failures++;
            $display("FAIL pre_reset got=%h want=efefef", post_img_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({post_frame_href, post_frame_clken, post_img_data} !== 26'h0) begin
            failures++;
            $display("FAIL midrst_out got=%h want=0",
                     {post_frame_href, post_frame_clken, post_img_data});
        end
        checks++;
        if ({curve_active, cfg_ready} !== 2'b01) begin
            failures++;
            $display("FAIL midrst_state got=%b want=01",
                     {curve_active, cfg_ready});
        end
        per_frame_href = 1'b0;
        per_frame_clken = 1'b0;
        per_img_data = '0;
        cur_exp = '0;
        cur_vs = 1'b0;
        cur_hr = 1'b0;
        cur_ck = 1'b0;
        exp_inv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vsync_frame(1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h10);
        drive(1'b0, 1'b1, 1'b1, 8'hC0);
        checks++;
        if (post_img_data !== 24'h101010) begin
            failures++;
            $display("FAIL post_rst_10 got=%h want=101010", post_img_data);
        end
        checks++;
        if (curve_active !== 1'b0) begin
            failures++;
            $display("FAIL post_rst_active got=%b want=0", curve_active);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (post_img_data !== 24'hC0C0C0) begin
            failures++;
            $display("FAIL post_rst_c0 got=%h want=c0c0c0", post_img_data);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_inverse_commit();
        test_pending_drop();
        test_swap_to_identity();
        test_commit_on_vsync();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
